// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for a streaming FFT core: feeds input frames and counts output frames.
// Optional output-frame length checker is built when FFT_FRAME_CTRL_LENCHK_EN is defined.
module fft_frame_ctrl #(
   parameter int unsigned FRAME_LEN  = 512,
   parameter int unsigned GAP_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic        continuous,
   input  logic        sink_ready,
   output logic        sink_valid,
   output logic        sink_sop,
   output logic        sink_eop,
   output logic [9:0]  sample_idx,
   input  logic        source_valid,
   input  logic        source_sop,
   input  logic        source_eop,
   output logic        busy,
   output logic        frame_done,
   output logic [15:0] out_frame_cnt,
   output logic        frame_err
);

   localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [9:0] LastIdx = 10'(FRAME_LEN - 1);
   localparam logic [GapW-1:0] GapLoad = GapW'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StFeed, StWaitOut, StGap} state_e;

   state_e          state_q, state_d;
   logic            valid_q, valid_d;
   logic            sop_q, sop_d;
   logic            eop_q, eop_d;
   logic [9:0]      idx_q, idx_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [15:0]     frame_cnt_q, frame_cnt_d;
   logic [GapW-1:0] gap_q, gap_d;
   logic            begin_frame;

   always_comb begin
      state_d     = state_q;
      valid_d     = valid_q;
      sop_d       = sop_q;
      eop_d       = eop_q;
      idx_d       = idx_q;
      done_d      = 1'b0;
      frame_cnt_d = frame_cnt_q;
      gap_d       = gap_q;
      begin_frame = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               begin_frame = 1'b1;
            end
         end
         StFeed: begin
            if (valid_q && sink_ready) begin
               if (idx_q == LastIdx) begin
                  state_d = StWaitOut;
                  valid_d = 1'b0;
                  sop_d   = 1'b0;
                  eop_d   = 1'b0;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + 10'd1;
                  sop_d = 1'b0;
                  eop_d = ((idx_q + 10'd1) == LastIdx);
               end
            end
         end
         StWaitOut: begin
            if (source_valid && source_eop) begin
               done_d      = 1'b1;
               frame_cnt_d = frame_cnt_q + 16'd1;
               if (!continuous) begin
                  state_d = StIdle;
               end else if (GAP_CYCLES == 0) begin
                  begin_frame = 1'b1;
               end else begin
                  state_d = StGap;
                  gap_d   = GapLoad;
               end
            end
         end
         StGap: begin
            if (gap_q == '0) begin
               begin_frame = 1'b1;
            end else begin
               gap_d = gap_q - 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      if (begin_frame) begin
         state_d = StFeed;
         valid_d = 1'b1;
         sop_d   = 1'b1;
         eop_d   = 1'b0;
         idx_d   = '0;
      end

      // Abort wins over every transition, including a completing output frame.
      if (abort) begin
         state_d     = StIdle;
         valid_d     = 1'b0;
         sop_d       = 1'b0;
         eop_d       = 1'b0;
         idx_d       = '0;
         done_d      = 1'b0;
         frame_cnt_d = frame_cnt_q;
      end

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         valid_q     <= 1'b0;
         sop_q       <= 1'b0;
         eop_q       <= 1'b0;
         idx_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         frame_cnt_q <= '0;
         gap_q       <= '0;
      end else begin
         state_q     <= state_d;
         valid_q     <= valid_d;
         sop_q       <= sop_d;
         eop_q       <= eop_d;
         idx_q       <= idx_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         frame_cnt_q <= frame_cnt_d;
         gap_q       <= gap_d;
      end
   end

   assign sink_valid    = valid_q;
   assign sink_sop      = sop_q;
   assign sink_eop      = eop_q;
   assign sample_idx    = idx_q;
   assign busy          = busy_q;
   assign frame_done    = done_q;
   assign out_frame_cnt = frame_cnt_q;

`ifdef FFT_FRAME_CTRL_LENCHK_EN
   localparam logic [10:0] FrameLenW = 11'(FRAME_LEN);

   logic [10:0] beat_q, beat_d;
   logic        counting_q, counting_d;
   logic        err_q, err_d;

   // Only output beats seen while waiting for an output frame are measured.
   always_comb begin
      beat_d     = beat_q;
      counting_d = counting_q;
      err_d      = err_q;
      if (state_q != StWaitOut) begin
         counting_d = 1'b0;
      end else if (source_valid) begin
         if (source_sop) begin
            if (counting_q) begin
               err_d = 1'b1;
            end
            beat_d     = 11'd1;
            counting_d = 1'b1;
         end else if (counting_q && (beat_q != '1)) begin
            beat_d = beat_q + 11'd1;
         end
         if (source_eop && (source_sop || counting_q)) begin
            counting_d = 1'b0;
            if (beat_d != FrameLenW) begin
               err_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         beat_q     <= '0;
         counting_q <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         beat_q     <= beat_d;
         counting_q <= counting_d;
         err_q      <= err_d;
      end
   end

   assign frame_err = err_q;
`else
   logic unused_source_sop;
   assign unused_source_sop = source_sop;
   assign frame_err         = 1'b0;
`endif

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Self-checking bench for fft_frame_ctrl (FRAME_LEN=8, GAP_CYCLES=2) with a frame-level model.
module tb_fft_frame_ctrl;

   localparam int FL  = 8;
   localparam int GAP = 2;
`ifdef FFT_FRAME_CTRL_LENCHK_EN
   localparam bit LenChk = 1'b1;
`else
   localparam bit LenChk = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, start, abort, continuous, sink_ready;
   logic        source_valid, source_sop, source_eop;
   logic        sink_valid, sink_sop, sink_eop, busy, frame_done, frame_err;
   logic [9:0]  sample_idx;
   logic [15:0] out_frame_cnt;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int t_eop = 0;
   int got_idx[$];

   always #5 clk = ~clk;

   fft_frame_ctrl #(.FRAME_LEN(FL), .GAP_CYCLES(GAP)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .abort        (abort),
      .continuous   (continuous),
      .sink_ready   (sink_ready),
      .sink_valid   (sink_valid),
      .sink_sop     (sink_sop),
      .sink_eop     (sink_eop),
      .sample_idx   (sample_idx),
      .source_valid (source_valid),
      .source_sop   (source_sop),
      .source_eop   (source_eop),
      .busy         (busy),
      .frame_done   (frame_done),
      .out_frame_cnt(out_frame_cnt),
      .frame_err    (frame_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   // Frame-level model: what the controller is doing, in terms of frames and beats.
   bit m_on = 1'b0, m_feed = 1'b0, m_wait = 1'b0, m_done = 1'b0, m_err = 1'b0;
   bit m_inframe = 1'b0;
   int m_pos = 0, m_gap = 0, m_beats = 0;
   logic [15:0] m_cnt = '0;

   always @(posedge clk) begin
      bit was_wait;
      cyc++;
      m_done = 1'b0;
      was_wait = m_wait;
      if (rst) begin
         m_on = 1'b1; m_feed = 1'b0; m_wait = 1'b0; m_gap = 0; m_pos = 0;
         m_cnt = '0; m_err = 1'b0; m_inframe = 1'b0;
      end else begin
         if (abort) begin
            m_feed = 1'b0; m_wait = 1'b0; m_gap = 0; m_pos = 0;
         end else if (m_feed) begin
            if (sink_ready) begin
               if (m_pos == FL - 1) begin
                  m_feed = 1'b0; m_wait = 1'b1; m_pos = 0;
               end else begin
                  m_pos++;
               end
            end
         end else if (m_wait) begin
            if (source_valid && source_eop) begin
               m_wait = 1'b0;
               m_done = 1'b1;
               m_cnt  = m_cnt + 16'd1;
               if (continuous) begin
                  if (GAP == 0) begin m_feed = 1'b1; m_pos = 0; end
                  else m_gap = GAP;
               end
            end
         end else if (m_gap > 0) begin
            m_gap--;
            if (m_gap == 0) begin m_feed = 1'b1; m_pos = 0; end
         end else if (start) begin
            m_feed = 1'b1; m_pos = 0;
         end
         if (LenChk) begin
            if (!was_wait) begin
               m_inframe = 1'b0;
            end else if (source_valid) begin
               if (source_sop) begin
                  if (m_inframe) m_err = 1'b1;
                  m_inframe = 1'b1;
                  m_beats = 1;
               end else if (m_inframe) begin
                  m_beats++;
               end
               if (source_eop && m_inframe) begin
                  m_inframe = 1'b0;
                  if (m_beats != FL) m_err = 1'b1;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (m_on) begin
         check("sink_valid", sink_valid, m_feed);
         check("sink_sop", sink_sop, m_feed && m_pos == 0);
         check("sink_eop", sink_eop, m_feed && m_pos == FL - 1);
         check("sample_idx", sample_idx, m_feed ? m_pos : 0);
         check("busy", busy, m_feed || m_wait || m_gap > 0);
         check("frame_done", frame_done, m_done);
         check("out_frame_cnt", out_frame_cnt, m_cnt);
         check("frame_err", frame_err, m_err);
      end
   end

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
   endtask

   // mode 0: always ready; mode 1: ready pattern 1,0,0,1,0,0,...
   task automatic run_feed(input int mode, input string tag);
      bit got_eop = 1'b0;
      got_idx.delete();
      for (int i = 0; i < 100; i++) begin
         sink_ready = (mode == 0) ? 1'b1 : (i % 3 == 0);
         if (sink_valid && sink_ready) begin
            got_idx.push_back(int'(sample_idx));
            if (sink_eop) begin got_eop = 1'b1; break; end
         end
         @(negedge clk);
      end
      check({tag, "_feed_eop_seen"}, got_eop, 1'b1);
      check({tag, "_beat_count"}, got_idx.size(), FL);
      for (int i = 0; i < got_idx.size() && i < FL; i++)
         check({tag, "_beat_idx"}, got_idx[i], i);
   endtask

   task automatic send_out(input int n, input bit stray_start);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         source_valid = 1'b1;
         source_sop   = (i == 0);
         source_eop   = (i == n - 1);
         start        = stray_start && (i == 0);
         if (i == n - 1) t_eop = cyc;
      end
      @(negedge clk);
      source_valid = 1'b0; source_sop = 1'b0; source_eop = 1'b0; start = 1'b0;
   endtask

   task automatic wait_sop(input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (sink_valid && sink_sop) begin seen = 1'b1; break; end
         @(negedge clk);
      end
      check({tag, "_sop_seen"}, seen, 1'b1);
      check({tag, "_sop_delay"}, cyc - t_eop, 3);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b1; abort = 1'b1; continuous = 1'b0; sink_ready = 1'b0;
      source_valid = 1'b0; source_sop = 1'b0; source_eop = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_over_start_busy", busy, 1'b0);
      check("rst_over_start_valid", sink_valid, 1'b0);
      rst = 1'b0; start = 1'b0; abort = 1'b0;
      @(negedge clk);
      check("reset_cnt", out_frame_cnt, 16'd0);
      check("reset_err", frame_err, 1'b0);

      // Single frame, always ready; stray start during output is ignored.
      sink_ready = 1'b1;
      pulse_start();
      check("t1_first_sop", sink_sop, 1'b1);
      run_feed(0, "t1");
      send_out(FL, 1'b1);
      check("t1_done", frame_done, 1'b1);
      check("t1_cnt", out_frame_cnt, 16'd1);
      check("t1_idle", busy, 1'b0);

      // Output beats while idle change nothing.
      send_out(FL, 1'b0);
      check("t1b_no_done", frame_done, 1'b0);
      check("t1b_cnt", out_frame_cnt, 16'd1);

      // Back-pressure.
      pulse_start();
      run_feed(1, "t2");
      send_out(FL, 1'b0);
      check("t2_cnt", out_frame_cnt, 16'd2);

      // Continuous mode, three frames.
      do_reset();
      sink_ready = 1'b1;
      continuous = 1'b1;
      pulse_start();
      for (int f = 0; f < 3; f++) begin
         run_feed(0, "t3");
         if (f == 2) continuous = 1'b0;
         send_out(FL, 1'b0);
         check("t3_done", frame_done, 1'b1);
         if (f == 0) begin
            continuous = 1'b0;
            @(negedge clk) continuous = 1'b1;
         end
         if (f < 2) wait_sop("t3");
      end
      check("t3_cnt", out_frame_cnt, 16'd3);
      check("t3_idle", busy, 1'b0);

      // Abort mid-feed.
      pulse_start();
      for (int i = 0; i < 20; i++) begin
         if (sink_valid && sample_idx == 10'd4) break;
         @(negedge clk);
      end
      check("t4_at_idx4", sample_idx, 10'd4);
      abort = 1'b1;
      @(negedge clk) abort = 1'b0;
      check("t4_valid", sink_valid, 1'b0);
      check("t4_busy", busy, 1'b0);
      check("t4_eop", sink_eop, 1'b0);
      check("t4_idx", sample_idx, 10'd0);
      pulse_start();
      check("t4_restart_sop", sink_sop, 1'b1);
      check("t4_restart_idx", sample_idx, 10'd0);
      run_feed(0, "t4");
      send_out(FL, 1'b0);
      check("t4_cnt", out_frame_cnt, 16'd4);

      // Short output frame, then a correct one.
      pulse_start();
      run_feed(0, "t5");
      send_out(FL - 1, 1'b0);
      check("t5_err_short", frame_err, LenChk);
      pulse_start();
      run_feed(0, "t5");
      send_out(FL, 1'b0);
      check("t5_err_sticky", frame_err, LenChk);
      check("t5_cnt", out_frame_cnt, 16'd6);
      do_reset();
      check("t5_err_cleared", frame_err, 1'b0);

      // Counter wrap from 0xFFFF.
      @(posedge clk);
      #1;
      force dut.frame_cnt_q = 16'hFFFF;
      m_cnt = 16'hFFFF;
      @(posedge clk);
      #1;
      release dut.frame_cnt_q;
      @(negedge clk);
      check("t6_preload", out_frame_cnt, 16'hFFFF);
      pulse_start();
      run_feed(0, "t6");
      send_out(FL, 1'b0);
      check("t6_done", frame_done, 1'b1);
      check("t6_wrap", out_frame_cnt, 16'd0);

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
